rr_req_stage: RTL
=================

# rr_req_stage

Per-port request staging buffer that sits directly upstream of the round-robin arbiter. Each of `NUM_PORTS` producers pushes payload words into its own small FIFO over a valid/ready handshake. The block presents a request vector built from non-empty FIFOs to the arbiter. On a one-hot grant it pops the granted port's head word into a single registered output slot with a valid/ready handshake to the consumer.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of producer ports; ≥2.
- `DATA_W`, 8: payload width in bits.
- `DEPTH`, 4: entries per port FIFO; power of two, ≥2.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `in_valid_i`  in  NUM_PORTS: per-port push valid.
- `in_data_i`  in  NUM_PORTS*DATA_W: port p payload in bits `[p*DATA_W +: DATA_W]`.
- `in_ready_o`  out  NUM_PORTS: per-port push ready.
- `request_o`  out  NUM_PORTS: request vector to the arbiter.
- `grant_i`  in  NUM_PORTS: grant from the arbiter; expected one-hot or zero.
- `out_valid_o`  out  1: output slot holds a word.
- `out_data_o`  out  DATA_W: output payload.
- `out_port_o`  out  $clog2(NUM_PORTS): source port index of `out_data_o`.
- `out_ready_i`  in  1: consumer accepts the output word.

## Operation
- **Push.** Port p pushes when `in_valid_i[p] & in_ready_o[p]`. `in_ready_o[p] = ~full[p]`, which is a function of registered state only. There is no same-cycle push-through when full.
- **Occupancy.** Per-port count is `$clog2(DEPTH+1)` bits wide. Read and write pointers are `$clog2(DEPTH)` bits and wrap naturally modulo `DEPTH`.
- **Slot free.** `slot_free = ~out_valid_o | out_ready_i`.
- **Request.** `request_o[p] = ~empty[p] & slot_free`. When the consumer stalls, every request is withdrawn.
- **Pop.** A pop of port p occurs when all of the following hold:
  - `grant_i` is exactly one-hot with bit p set;
  - `~empty[p]`;
  - `slot_free`.
  
  On a pop, the head word loads into `out_data_o`, `out_port_o <= p`, and `out_valid_o <= 1`.
- **Ignored grants.** A grant is dropped with no state change if it is multi-hot, targets an empty FIFO, or arrives while the slot is not free. The port keeps requesting.
- **Output slot.** If `out_valid_o & out_ready_i` and there is no pop in the same cycle, `out_valid_o <= 0`. If a pop and an accept coincide, the slot reloads back-to-back with no bubble.
- **Push and pop together.** Push and pop on the same port in the same cycle are both performed, and the count is unchanged. This holds when full: the pop does not make room in that same cycle. It also holds when empty: no pop occurs, the push lands, and the count becomes 1.
- **Ordering.** FIFO order is preserved within each port. Inter-port order is whatever the arbiter grants.

## Timing
- **Reset values** (synchronous, applied on the rising edge while `reset=1`):
  - all counts and pointers 0;
  - `in_ready_o` all 1s after the reset edge (all 0s while reset is asserted);
  - `request_o` 0;
  - `out_valid_o` 0, `out_data_o` 0, `out_port_o` 0.
- **Reset mid-operation.** Discards all buffered and output words. No partial handshakes survive.
- **Push to request.** A word pushed at edge N gives `request_o[p]=1` after edge N, in cycle N+1.
- **Grant to output.** A grant sampled at edge M that pops produces `out_valid_o=1` after edge M.
- **Full throughput.** One word per cycle total across all ports when the arbiter grants every cycle and `out_ready_i=1`.
- **Output stability.** `out_data_o` and `out_port_o` are stable while `out_valid_o & ~out_ready_i`.

## Configuration
- **`RR_STAGE_GRANT_CHECK_EN` defined:** adds output `grant_err_o`, 1 bit, reset 0, sticky until `reset`. It is set on any cycle where `grant_i` is non-zero and any of the following hold:
  - `grant_i` is multi-hot;
  - the granted FIFO is empty;
  - `slot_free=0`.
- **Not defined:** the port and its logic are absent. Bad grants are silently ignored exactly as described under Operation.

## Structure
- **Package `rr_stage_pkg`:**
  - `port_idx_t` typedef, sized by a package-level `NUM_PORTS` default;
  - a `onehot_to_idx` function;
  - a `is_onehot` function.
- **Sub-module `rr_port_fifo`** (parameters `DATA_W`, `DEPTH`):
  - push and pop strobes;
  - `full`, `empty` and `head` outputs;
  - instantiated `NUM_PORTS` times in a generate loop.
- **Top level** holds the request gating, grant decode and output slot.

## Test plan
- **Reset.** Assert `reset` with `in_valid_i=4'b1111` → after release `in_ready_o=4'b1111`, `request_o=0`, `out_valid_o=0`; no word appears.
- **Single port round trip.** Push 0xA5 on port 2; grant `4'b0100` next cycle with `out_ready_i=1` → `out_data_o=0xA5`, `out_port_o=2`, `out_valid_o` for one cycle, `request_o[2]` falls.
- **Fill and overflow.** Push `DEPTH`+1 words on port 0 with no grants → `in_ready_o[0]=0` after 4 pushes; the 5th word is held by the producer; draining with 4 grants returns words in order.
- **Backpressure.** Output slot full and `out_ready_i=0`, grant `4'b0001` → `request_o=0`, no pop; slot data unchanged; port 0 count unchanged.
- **Bad grants.** Grant `4'b0011`, or grant `4'b1000` with port 3 empty → no pop; with `RR_STAGE_GRANT_CHECK_EN`, `grant_err_o=1` and it stays 1.
- **Back-to-back.** All ports hold 2 words, grants rotate 1, 2, 4, 8, 1, 2, 4, 8 with `out_ready_i=1` → 8 consecutive valid cycles, with `out_port_o` sequence 0, 1, 2, 3, 0, 1, 2, 3.

Source files
------------

// File: rtl/rr_stage_pkg.sv
// Shared types and helpers for the round-robin request staging buffer.
package rr_stage_pkg;

    localparam int unsigned NUM_PORTS = 4;
    // Widest grant vector the helper functions accept.
    localparam int unsigned MAX_PORTS = 32;

    typedef logic [$clog2(NUM_PORTS)-1:0] port_idx_t;

    function automatic logic is_onehot(input logic [MAX_PORTS-1:0] v);
        return (v != '0) && ((v & (v - 32'd1)) == '0);
    endfunction

    function automatic int unsigned onehot_to_idx(input logic [MAX_PORTS-1:0] v);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_PORTS; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_port_fifo.sv
// Single-port payload FIFO feeding one request line of the staging buffer.
// Push/pop strobes are pre-qualified by the caller against full/empty.
module rr_port_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [DATA_W-1:0] head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Next pointer, occupancy and storage state from the push/pop strobes.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
        count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        if (push_i) mem_d[wr_ptr_q] = push_data_i;
    end

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/rr_req_stage.sv
// Per-port request staging buffer upstream of a round-robin arbiter.
// Optional RR_STAGE_GRANT_CHECK_EN adds a sticky grant_err_o flag.
module rr_req_stage
    import rr_stage_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          in_valid_i,
    input  logic [NUM_PORTS*DATA_W-1:0]   in_data_i,
    output logic [NUM_PORTS-1:0]          in_ready_o,
    output logic [NUM_PORTS-1:0]          request_o,
    input  logic [NUM_PORTS-1:0]          grant_i,
    output logic                          out_valid_o,
    output logic [DATA_W-1:0]             out_data_o,
    output logic [$clog2(NUM_PORTS)-1:0]  out_port_o,
    input  logic                          out_ready_i
`ifdef RR_STAGE_GRANT_CHECK_EN
    ,
    output logic                          grant_err_o
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0] full, empty, push, pop;
    logic [DATA_W-1:0]    head [NUM_PORTS];
    logic [MAX_PORTS-1:0] grant_ext;
    logic                 grant_onehot;
    logic [IDX_W-1:0]     grant_idx;
    logic                 slot_free;

    logic                 out_valid_q, out_valid_d;
    logic [DATA_W-1:0]    out_data_q, out_data_d;
    logic [IDX_W-1:0]     out_port_q, out_port_d;

    // Ready is held low while reset is asserted so no word is taken in.
    assign in_ready_o = ~full & {NUM_PORTS{~reset}};
    assign push       = in_valid_i & in_ready_o;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        rr_port_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk         (clk),
            .reset       (reset),
            .push_i      (push[p]),
            .push_data_i (in_data_i[p*DATA_W +: DATA_W]),
            .pop_i       (pop[p]),
            .full_o      (full[p]),
            .empty_o     (empty[p]),
            .head_o      (head[p])
        );
    end

    // Request gating and grant decode into per-port pop strobes.
    always_comb begin
        grant_ext                = '0;
        grant_ext[NUM_PORTS-1:0] = grant_i;
        grant_onehot             = is_onehot(grant_ext);
        grant_idx                = IDX_W'(onehot_to_idx(grant_ext));
        slot_free                = ~out_valid_q | out_ready_i;
        request_o                = ~empty & {NUM_PORTS{slot_free}};
        pop                      = (grant_onehot && slot_free) ? (grant_i & ~empty) : '0;
    end

    // Output slot: reload on pop (even while being accepted), else drain on accept.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_port_d  = out_port_q;
        if (|pop) begin
            out_valid_d = 1'b1;
            out_data_d  = head[grant_idx];
            out_port_d  = grant_idx;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // Output slot registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_port_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_port_q  <= out_port_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_port_o  = out_port_q;

`ifdef RR_STAGE_GRANT_CHECK_EN
    logic grant_err_q, grant_err_d;
    logic grant_bad;

    // Any non-zero grant that cannot pop raises a sticky error.
    always_comb begin
        grant_bad   = (grant_i != '0) &&
                      (!grant_onehot || ((grant_i & ~empty) == '0) || !slot_free);
        grant_err_d = grant_err_q | grant_bad;
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) grant_err_q <= 1'b0;
        else       grant_err_q <= grant_err_d;
    end

    assign grant_err_o = grant_err_q;
`endif

endmodule
